mac_seq_ctrl: RTL and testbench
===============================

// Module: mac_seq_ctrl
// PURPOSE
// Sequencing controller on the other side of the FinalMAC down-counter interface.
// - Drives the counter's ld_N / dec_N and reads back its dout.
// - Issues operand fetches over a req/vld handshake, and issues mac_en / acc_clr to the MAC datapath.
// - Raises a one-cycle done when N products have been accumulated.
// PARAMETERS
// CW  16  width of N and of the counter value
// AW  10  width of the operand address
// PORTS
// clk       in   1   rising-edge clock
// clr       in   1   asynchronous, active-high reset
// start     in   1   begin a run; sampled only in IDLE
// abort     in   1   synchronous cancel of a run in progress
// N         in   CW  number of products; latched on accepted start
// busy      out  1   high from the cycle after start until done
// done      out  1   one-cycle pulse: run complete
// err       out  1   sticky; counter read 0 while in FETCH; cleared by next start
// cnt_ld    out  1   to counter ld_N
// cnt_dec   out  1   to counter dec_N
// cnt_val   in   CW  from counter dout
// cnt_n     out  CW  load value for counter N (latched copy of N)
// op_req    out  1   operand request
// op_vld    in   1   operand pair present this cycle
// op_addr   out  AW  operand index
// acc_clr   out  1   clear the accumulator
// mac_en    out  1   accumulate the current operand pair
// BEHAVIOUR
// - Reset (clr=1, async): state=IDLE; every output 0; cnt_n=0; op_addr=0; err=0.
// - States: IDLE, LOAD, FETCH, FINISH. Next-state and data registers update on the clk rising edge.
// - IDLE
//   - start=1 and N!=0: latch cnt_n=N, op_addr=0, err=0 -> LOAD.
//   - start=1 and N==0: err=0 -> FINISH. No load and no MAC activity.
// - LOAD: cnt_ld=1 and acc_clr=1 (Moore, exactly one cycle) -> FETCH. The counter holds N from the next cycle.
// - FETCH
//   - op_req=1 (Moore).
//   - On op_vld=1 (Mealy, same cycle): mac_en=1, cnt_dec=1, op_addr += 1 (wraps modulo 2^AW).
//   - op_vld=1 and cnt_val==1: last product -> FINISH.
//   - op_vld=0: hold in FETCH. Stalls of any length are legal; mac_en, cnt_dec and op_addr are held.
//   - cnt_val==0 while in FETCH: set err=1 -> FINISH. mac_en and cnt_dec stay 0 that cycle.
// - FINISH: done=1 for one cycle -> IDLE. A start during FINISH is ignored.
// - busy=1 whenever state != IDLE.
// - abort=1 in LOAD or FETCH -> IDLE next cycle; no done; op_req drops. abort takes priority over op_vld, so no mac_en / cnt_dec that cycle.
// - start while busy: ignored.
// - clr asserted mid-run: immediate return to IDLE with all outputs 0; the partial run is lost.
// - Latency with no stalls: done is asserted N+2 cycles after the start cycle (N>=1), and 1 cycle after for N==0.
// - Throughput: one product per cycle while op_vld stays high.
// - Width: cnt_val is compared at full CW width; there is no saturation (the counter owns the arithmetic).
// STRUCTURE
// - Shared package mac_pkg: state encoding localparams (IDLE=2'd0, LOAD=2'd1, FETCH=2'd2, FINISH=2'd3) and default CW/AW.
// - No sub-module: a single FSM plus the cnt_n, op_addr and err registers.
// - The counter stays an external instance, wired cnt_ld->ld_N, cnt_dec->dec_N, cnt_n->N, dout->cnt_val.
// TESTING (bench instantiates the real counter alongside this block)
// 1. N=7, op_vld tied 1, start pulse
//    -> cnt_ld for 1 cycle; 7 mac_en cycles; op_addr 0..6 then 7; done 9 cycles after start; cnt_val=0.
// 2. N=3, op_vld low for 2 cycles between products
//    -> exactly 3 mac_en; done only after the 3rd op_vld; op_addr=3.
// 3. N=0, start -> done the next cycle; no cnt_ld, no mac_en, no op_req.
// 4. N=5; abort after the 2nd product -> IDLE; no done; exactly 2 mac_en; busy low the next cycle.
// 5. N=4; clr asserted mid-FETCH -> all outputs 0 immediately; a new start N=2 then completes normally.
// 6. start asserted during busy and during FINISH -> ignored; cnt_n unchanged.
//    Forcing cnt_val=0 in FETCH -> err=1, then done; err cleared by the next start.

Source files
------------

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared encodings and default widths for the MAC sequencing controller
package mac_pkg;

    localparam int CW_DEF = 16;
    localparam int AW_DEF = 10;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_LOAD   = 2'd1;
    localparam state_t ST_FETCH  = 2'd2;
    localparam state_t ST_FINISH = 2'd3;

endpackage

// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - sequences counter load/decrement, operand fetch and MAC enables for N products
module mac_seq_ctrl
    import mac_pkg::*;
#(
    parameter int CW = CW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] N,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          cnt_ld,
    output logic          cnt_dec,
    input  logic [CW-1:0] cnt_val,
    output logic [CW-1:0] cnt_n,
    output logic          op_req,
    input  logic          op_vld,
    output logic [AW-1:0] op_addr,
    output logic          acc_clr,
    output logic          mac_en
);

    state_t state;
    state_t state_nxt;

    logic cnt_zero;
    logic cnt_last;
    logic fire;

    assign cnt_zero = (cnt_val == '0);
    assign cnt_last = (cnt_val == CW'(1));

    // A product is consumed only when the counter is sane and the run is not being cancelled.
    assign fire = (state == ST_FETCH) && op_vld && !abort && !cnt_zero;

    // State register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection; abort outranks the zero-count error, which outranks a product.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (N != '0) ? ST_LOAD : ST_FINISH;
                end
            end
            ST_LOAD: begin
                state_nxt = abort ? ST_IDLE : ST_FETCH;
            end
            ST_FETCH: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (cnt_zero) begin
                    state_nxt = ST_FINISH;
                end else if (op_vld && cnt_last) begin
                    state_nxt = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Control outputs: phase strobes follow the state, product strobes follow op_vld in FETCH.
    always_comb begin
        busy    = (state != ST_IDLE);
        done    = (state == ST_FINISH);
        cnt_ld  = (state == ST_LOAD);
        acc_clr = (state == ST_LOAD);
        op_req  = (state == ST_FETCH);
        mac_en  = fire;
        cnt_dec = fire;
    end

    // Run registers: latched N, operand index and the sticky error flag.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_n   <= '0;
            op_addr <= '0;
            err     <= 1'b0;
        end else begin
            if (state == ST_IDLE && start) begin
                err <= 1'b0;
                if (N != '0) begin
                    cnt_n   <= N;
                    op_addr <= '0;
                end
            end
            if (fire) begin
                op_addr <= op_addr + AW'(1);
            end
            if (state == ST_FETCH && !abort && cnt_zero) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb/tb_mac_seq_ctrl.sv - self-checking bench for mac_seq_ctrl with a behavioural down-counter
module tb_mac_seq_ctrl;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] N = 16'd0;
    logic        busy, done, err, cnt_ld, cnt_dec, op_req, acc_clr, mac_en;
    logic [15:0] cnt_val, cnt_n;
    logic [9:0]  op_addr;
    logic        op_vld = 1'b0;
    logic        force0 = 1'b0;
    logic [15:0] ctr_q;

    int n_asserts = 0;
    int n_fail = 0;
    int cyc = 0;

    // run statistics gathered from the DUT
    int mac_cnt, ld_cnt, req_cnt, done_cnt, done_cyc, last_mac_cyc, s_cyc;
    bit done_seen;

    // reference model state
    bit m_run, m_loaded, m_finishing, m_err;
    int m_n, m_addr, m_prod, m_ctr;

    always #5 clk = ~clk;

    mac_seq_ctrl #(.CW(16), .AW(10)) dut (
        .clk(clk), .clr(clr), .start(start), .abort(abort), .N(N),
        .busy(busy), .done(done), .err(err), .cnt_ld(cnt_ld), .cnt_dec(cnt_dec),
        .cnt_val(cnt_val), .cnt_n(cnt_n), .op_req(op_req), .op_vld(op_vld),
        .op_addr(op_addr), .acc_clr(acc_clr), .mac_en(mac_en)
    );

    // external down-counter: ld_N loads, dec_N decrements, dout feeds cnt_val
    always @(posedge clk or posedge clr) begin
        if (clr) ctr_q <= 16'd0;
        else if (cnt_ld) ctr_q <= cnt_n;
        else if (cnt_dec) ctr_q <= ctr_q - 16'd1;
    end
    assign cnt_val = force0 ? 16'd0 : ctr_q;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // per-cycle model and compare
    always @(negedge clk) begin
        bit e_busy, e_done, e_err, e_ld, e_dec, e_req, e_clr, e_mac;
        int e_n, e_addr;
        e_busy = 0; e_done = 0; e_ld = 0; e_dec = 0; e_req = 0; e_clr = 0; e_mac = 0;
        e_err = m_err; e_n = m_n; e_addr = m_addr;
        if (clr) begin
            m_run = 0; m_loaded = 0; m_finishing = 0; m_err = 0;
            m_n = 0; m_addr = 0; m_prod = 0; m_ctr = 0;
            e_err = 0; e_n = 0; e_addr = 0;
        end else begin
            e_busy = m_run;
            chk("counter", ctr_q, m_ctr);
            if (!m_run) begin
                if (start) begin
                    m_err = 0; m_run = 1;
                    if (N != 0) begin
                        m_n = N; m_addr = 0; m_prod = 0; m_loaded = 0; m_finishing = 0;
                    end else begin
                        m_finishing = 1;
                    end
                end
            end else if (m_finishing) begin
                e_done = 1; m_run = 0; m_finishing = 0;
            end else if (!m_loaded) begin
                e_ld = 1; e_clr = 1;
                if (abort) m_run = 0; else m_loaded = 1;
            end else begin
                e_req = 1;
                if (abort) begin
                    m_run = 0; m_loaded = 0;
                end else if (force0) begin
                    m_err = 1; m_finishing = 1; m_loaded = 0;
                end else if (op_vld) begin
                    e_mac = 1; e_dec = 1;
                    m_prod++; m_addr = (m_addr + 1) % 1024;
                    if (m_prod == m_n) begin
                        m_finishing = 1; m_loaded = 0;
                    end
                end
            end
            if (e_ld) m_ctr = m_n;
            else if (e_dec) m_ctr = m_ctr - 1;
        end
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("err", err, e_err);
        chk("cnt_ld", cnt_ld, e_ld);
        chk("cnt_dec", cnt_dec, e_dec);
        chk("op_req", op_req, e_req);
        chk("acc_clr", acc_clr, e_clr);
        chk("mac_en", mac_en, e_mac);
        chk("cnt_n", cnt_n, e_n);
        chk("op_addr", op_addr, e_addr);
        if (mac_en) begin mac_cnt++; last_mac_cyc = cyc; end
        if (cnt_ld) ld_cnt++;
        if (op_req) req_cnt++;
        if (done) begin done_cnt++; done_cyc = cyc; done_seen = 1; end
    end

    task automatic clear_stats();
        mac_cnt = 0; ld_cnt = 0; req_cnt = 0; done_cnt = 0;
        done_cyc = -1; last_mac_cyc = -1; done_seen = 0;
    endtask

    task automatic pulse_start(input int n);
        @(posedge clk); #1;
        start = 1; N = 16'(n); s_cyc = cyc;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget && !done_seen; i++) begin
            @(negedge clk); #1;
        end
        if (!done_seen) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_req(input string name, input int budget);
        for (int i = 0; i < budget && !op_req; i++) begin
            @(negedge clk); #1;
        end
        if (!op_req) chk({name, "_req_timeout"}, 0, 1);
    endtask

    task automatic wait_macs(input string name, input int k, input int budget);
        for (int i = 0; i < budget && mac_cnt < k; i++) begin
            @(negedge clk); #1;
        end
        if (mac_cnt < k) chk({name, "_mac_timeout"}, mac_cnt, k);
    endtask

    initial begin
        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_cnt_n", cnt_n, 0);
        chk("rst_op_addr", op_addr, 0);
        chk("rst_err", err, 0);
        clr = 0;

        // 1: N=7, no stalls
        clear_stats(); op_vld = 1;
        pulse_start(7);
        wait_done("t1", 30);
        chk("t1_latency", done_cyc - s_cyc, 9);
        chk("t1_macs", mac_cnt, 7);
        chk("t1_loads", ld_cnt, 1);
        chk("t1_addr", op_addr, 7);
        chk("t1_cnt_val", cnt_val, 0);

        // 2: N=3 with two-cycle gaps between products
        repeat (2) @(posedge clk);
        clear_stats(); op_vld = 0;
        pulse_start(3);
        wait_req("t2", 10);
        for (int p = 0; p < 3; p++) begin
            @(posedge clk); #1; op_vld = 1;
            @(posedge clk); #1; op_vld = 0;
            @(posedge clk); #1;
        end
        wait_done("t2", 10);
        chk("t2_macs", mac_cnt, 3);
        chk("t2_done_after_last", done_cyc - last_mac_cyc, 1);
        chk("t2_addr", op_addr, 3);

        // 3: N=0
        clear_stats(); op_vld = 1;
        pulse_start(0);
        wait_done("t3", 10);
        chk("t3_latency", done_cyc - s_cyc, 1);
        chk("t3_loads", ld_cnt, 0);
        chk("t3_macs", mac_cnt, 0);
        chk("t3_reqs", req_cnt, 0);

        // 4: N=5, abort after the second product
        repeat (2) @(posedge clk);
        clear_stats();
        pulse_start(5);
        wait_macs("t4", 2, 20);
        @(posedge clk); #1; abort = 1;
        @(posedge clk); #1; abort = 0;
        chk("t4_busy", busy, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("t4_macs", mac_cnt, 2);
        chk("t4_done", done_cnt, 0);

        // 5: N=4, clr mid-FETCH, then N=2 completes
        clear_stats();
        pulse_start(4);
        wait_macs("t5", 2, 20);
        @(posedge clk); #1; clr = 1; #1;
        chk("t5_busy", busy, 0);
        chk("t5_op_req", op_req, 0);
        chk("t5_mac_en", mac_en, 0);
        chk("t5_cnt_n", cnt_n, 0);
        chk("t5_op_addr", op_addr, 0);
        @(posedge clk); #1; clr = 0;
        clear_stats();
        pulse_start(2);
        wait_done("t5b", 20);
        chk("t5b_macs", mac_cnt, 2);
        chk("t5b_latency", done_cyc - s_cyc, 4);

        // 6: start while busy / in FINISH ignored; forced zero count raises err
        repeat (2) @(posedge clk);
        clear_stats(); op_vld = 0;
        pulse_start(3);
        wait_req("t6", 10);
        @(posedge clk); #1; start = 1; N = 16'd9;
        @(posedge clk); #1; start = 0;
        chk("t6_cnt_n_busy", cnt_n, 3);
        force0 = 1;
        @(posedge clk); #1; force0 = 0; start = 1; N = 16'd9;
        chk("t6_err", err, 1);
        chk("t6_finish", done, 1);
        @(posedge clk); #1; start = 0;
        chk("t6_idle", busy, 0);
        chk("t6_cnt_n_finish", cnt_n, 3);
        chk("t6_err_sticky", err, 1);
        chk("t6_macs", mac_cnt, 0);
        clear_stats(); op_vld = 1;
        pulse_start(1);
        chk("t6_err_cleared", err, 0);
        wait_done("t6b", 10);
        chk("t6b_macs", mac_cnt, 1);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
